control_trace_encoder: RTL and testbench
========================================

// Module: control_trace_encoder
// PURPOSE
//  Inverse of the LEGLite control decoder. It samples the control-signal bundle driven
//  into the datapath each accepted cycle and re-encodes it to the 4-bit opcode that
//  produced it. It packs PACK opcodes per output word and buffers the words in a
//  DEPTH-entry FIFO for the debug/trace port. It flags bundles that no legal opcode produces.
// PARAMETERS
//  PACK   4  opcodes per output word; word width W = 4*PACK, slot 0 in bits [3:0]
//  DEPTH  4  output FIFO depth in words; power of 2, >= 2
// PORTS
//  clock         in   1       single clock, all state on rising edge
//  reset         in   1       asynchronous, active-low; 0 clears all state immediately
//  in_valid      in   1       control bundle below is valid this cycle
//  in_ready      out  1       encoder can accept a bundle this cycle
//  reg2loc       in   1       control bundle fields, same meaning as the decoder outputs
//  uncondbranch  in   1
//  branch        in   1
//  memread       in   1
//  memtoreg      in   1
//  alu_select    in   3
//  memwrite      in   1
//  alusrc        in   1
//  regwrite      in   1
//  flush         in   1       one-cycle pulse: emit the partial word now
//  out_valid     out  1       FIFO head word valid
//  out_ready     in   1       consumer takes head word when out_valid & out_ready
//  out_word      out  W       packed opcodes
//  out_count     out  clog2(PACK+1)  number of valid slots in out_word (1..PACK)
//  illegal_seen  out  1       sticky: some accepted bundle matched no opcode
//  illegal_count out  8       saturating count of illegal bundles
// BEHAVIOUR
//  Reset: out_valid=0, out_word=0, out_count=0, illegal_seen=0, illegal_count=0,
//   slot counter=0, FIFO empty, flush_pending=0. in_ready=1 once reset is released.
//  Encode (combinational, exact match on all 11 bits, order-independent):
//   ADD  0: r2l0 ub0 br0 mr0 m2r0 alu0 mw0 src0 rw1
//   LD   5: r2l0 ub0 br0 mr1 m2r1 alu0 mw0 src1 rw1
//   ST   6: r2l1 ub0 br0 mr0 m2r0 alu0 mw1 src1 rw0
//   CBZ  7: r2l1 ub0 br1 mr0 m2r0 alu2 mw0 src0 rw0
//   ADDI 8: r2l0 ub0 br0 mr0 m2r0 alu0 mw0 src1 rw1
//   ANDI 9: r2l0 ub0 br0 mr0 m2r0 alu4 mw0 src1 rw1
//   all-zero bundle (decoder default) -> 4'hF (NOP)
//   any other bundle -> 4'hE (ILLEGAL); increments illegal_count (saturates at 255)
//   and sets illegal_seen. illegal_seen is cleared only by reset.
//  Accept occurs when in_valid & in_ready. in_ready = !fifo_full & !flush_pending.
//   in_valid while in_ready=0 is ignored; the source holds the bundle.
//  Packing: the opcode is written to the current slot and the slot counter increments.
//   When the slot reaches PACK, the word is pushed with out_count=PACK and the slot
//   resets to 0. A word completed at edge N is visible on out_valid after edge N
//   (1-cycle latency).
//  Flush: if slot>0, the partial word is pushed, unused slots are padded with 4'hF,
//   out_count=slot, and slot resets to 0. If slot==0, flush is a no-op.
//   If the FIFO is full, flush sets flush_pending. The push occurs on the first cycle
//   with space, and flush_pending then clears.
//  Accept and flush in the same cycle: the bundle is packed first, then the word is
//   pushed with out_count=slot+1. A completed full word is pushed once, not twice.
//  FIFO: first-word-fall-through. Push and pop in the same cycle are both allowed
//   when full, because pop frees the entry. Occupancy never exceeds DEPTH.
//   out_word/out_count are held stable while out_valid & !out_ready.
//  Reset mid-word or mid-stall discards the partial word and all FIFO contents.
// TESTING
//  1 Accept ADD,LD,ST,CBZ bundles back-to-back, out_ready=1 -> one word 16'h7650,
//    out_count=4.
//  2 Accept ADDI,ANDI then flush -> 16'hFF98, out_count=2. A second flush pulse
//    -> no new word.
//  3 Hold out_ready=0 and stream 16 bundles -> 4 words queued, in_ready=0.
//    Raise out_ready -> words drain in order; in_ready returns 1 the cycle after the
//    first pop.
//  4 Bundle alu_select=3 with all else 0 -> slot gets 4'hE, illegal_seen=1,
//    illegal_count=1. 300 illegal bundles -> illegal_count=255.
//  5 Same-cycle flush with the 4th accept -> exactly one word, out_count=4.
//    Flush while FIFO full -> pending, pushed when one word pops.
//  6 Assert reset low mid-word with 2 words queued -> out_valid=0 immediately.
//    After release, the next 4 accepts form a fresh word with no stale slots.

Source files
------------

// File: rtl/control_trace_encoder.sv
// Re-encodes the datapath control bundle to its LEGLite opcode, packs PACK opcodes
// per word and queues the words in a small first-word-fall-through trace FIFO.
module control_trace_encoder #(
    parameter int PACK  = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         reg2loc_i,
    input  logic                         uncondbranch_i,
    input  logic                         branch_i,
    input  logic                         memread_i,
    input  logic                         memtoreg_i,
    input  logic [2:0]                   alu_select_i,
    input  logic                         memwrite_i,
    input  logic                         alusrc_i,
    input  logic                         regwrite_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [4*PACK-1:0]            out_word_o,
    output logic [$clog2(PACK+1)-1:0]    out_count_o,
    output logic                         illegal_seen_o,
    output logic [7:0]                   illegal_count_o
);

    localparam int W  = 4 * PACK;
    localparam int CW = $clog2(PACK + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [10:0]   bundle;
    logic [3:0]    opcode;

    logic [CW-1:0] slot_q, slot_d, slot_inc;
    logic [W-1:0]  word_q, word_d, word_upd;
    logic          flush_pending_q, flush_pending_d;
    logic          illegal_seen_q, illegal_seen_d;
    logic [7:0]    illegal_count_q, illegal_count_d;

    logic [W-1:0]  mem_word_q [DEPTH];
    logic [CW-1:0] mem_cnt_q  [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d;

    logic accept, push, pop, full, space, flush_req, last_slot, illegal;

    assign bundle = {reg2loc_i, uncondbranch_i, branch_i, memread_i, memtoreg_i,
                     alu_select_i, memwrite_i, alusrc_i, regwrite_i};

    // Exact match on all 11 bits; anything outside the table is reported as illegal.
    always_comb begin
        opcode = 4'hE;
        case (bundle)
            11'b00000_000_001: opcode = 4'h0;
            11'b00011_000_011: opcode = 4'h5;
            11'b10000_000_110: opcode = 4'h6;
            11'b10100_010_000: opcode = 4'h7;
            11'b00000_000_011: opcode = 4'h8;
            11'b00000_100_011: opcode = 4'h9;
            11'b00000_000_000: opcode = 4'hF;
            default:           opcode = 4'hE;
        endcase
    end

    assign full        = (occ_q == OW'(DEPTH));
    assign out_valid_o = (occ_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign space       = !full | pop;
    assign in_ready_o  = !full & !flush_pending_q;
    assign accept      = in_valid_i & in_ready_o;
    assign flush_req   = flush_i | flush_pending_q;
    assign illegal     = accept & (opcode == 4'hE);

    assign out_word_o  = out_valid_o ? mem_word_q[rd_ptr_q] : '0;
    assign out_count_o = out_valid_o ? mem_cnt_q[rd_ptr_q]  : '0;

    assign illegal_seen_o  = illegal_seen_q;
    assign illegal_count_o = illegal_count_q;

    // word_q keeps unused slots at 4'hF so a flushed partial word is already padded.
    always_comb begin
        word_upd = word_q;
        for (int i = 0; i < PACK; i++) begin
            if (accept && (slot_q == CW'(i))) begin
                word_upd[4*i +: 4] = opcode;
            end
        end
        slot_inc  = slot_q + CW'(accept);
        last_slot = accept && (slot_q == CW'(PACK - 1));
        push      = last_slot | (flush_req & (slot_inc != '0) & space);

        slot_d          = push ? '0 : slot_inc;
        word_d          = push ? {W{1'b1}} : word_upd;
        flush_pending_d = flush_req & (slot_inc != '0) & !push;

        illegal_seen_d  = illegal_seen_q | illegal;
        illegal_count_d = illegal_count_q;
        if (illegal && (illegal_count_q != 8'hFF)) begin
            illegal_count_d = illegal_count_q + 8'd1;
        end

        occ_d = occ_q + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot_q          <= '0;
            word_q          <= {W{1'b1}};
            flush_pending_q <= 1'b0;
            illegal_seen_q  <= 1'b0;
            illegal_count_q <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_word_q[i] <= '0;
                mem_cnt_q[i]  <= '0;
            end
        end else begin
            slot_q          <= slot_d;
            word_q          <= word_d;
            flush_pending_q <= flush_pending_d;
            illegal_seen_q  <= illegal_seen_d;
            illegal_count_q <= illegal_count_d;
            occ_q           <= occ_d;
            if (push) begin
                mem_word_q[wr_ptr_q] <= word_upd;
                mem_cnt_q[wr_ptr_q]  <= slot_inc;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_trace_encoder.sv
// Scoreboard bench: a table-driven opcode model forms expected trace words;
// a separate monitor pops and compares them as the encoder presents words.
module tb_control_trace_encoder;

    localparam int PACK  = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] word;
        logic [2:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, illegal_seen;
    logic [10:0] bnd;
    logic [15:0] out_word;
    logic [2:0]  out_count;
    logic [7:0]  illegal_count;

    exp_t        expq[$];
    logic [3:0]  slots[$];
    int          ill_n;
    int          checks = 0;
    int          passes = 0;

    logic [10:0] tbl_b  [7];
    logic [3:0]  tbl_op [7];

    always #5 clk = ~clk;

    control_trace_encoder #(.PACK(PACK), .DEPTH(DEPTH)) dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .reg2loc_i      (bnd[10]),
        .uncondbranch_i (bnd[9]),
        .branch_i       (bnd[8]),
        .memread_i      (bnd[7]),
        .memtoreg_i     (bnd[6]),
        .alu_select_i   (bnd[5:3]),
        .memwrite_i     (bnd[2]),
        .alusrc_i       (bnd[1]),
        .regwrite_i     (bnd[0]),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_word_o     (out_word),
        .out_count_o    (out_count),
        .illegal_seen_o (illegal_seen),
        .illegal_count_o(illegal_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [3:0] ref_encode(input logic [10:0] b);
        for (int i = 0; i < 7; i++) if (b == tbl_b[i]) return tbl_op[i];
        return 4'hE;
    endfunction

    function automatic void form_word();
        exp_t e;
        e.word = 16'hFFFF;
        for (int i = 0; i < slots.size(); i++) e.word[4*i +: 4] = slots[i];
        e.cnt = 3'(slots.size());
        expq.push_back(e);
        slots.delete();
    endfunction

    // One clock of stimulus; the model is updated for what the next rising edge will do.
    task automatic cycle(input logic v, input logic [10:0] b, input logic fl,
                         input logic ordy, output bit acc);
        logic [3:0] op;
        @(negedge clk);
        in_valid  = v;
        bnd       = b;
        flush     = fl;
        out_ready = ordy;
        acc = v && in_ready;
        if (acc) begin
            op = ref_encode(b);
            slots.push_back(op);
            if (op == 4'hE) ill_n++;
            if (slots.size() == PACK) form_word();
        end
        if (fl && slots.size() > 0) form_word();
    endtask

    task automatic send(input logic [10:0] b, input logic fl, input logic ordy);
        bit acc;
        int tries = 0;
        do begin
            cycle(1'b1, b, fl, ordy, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 11'h0, 1'b0, ordy, acc);
    endtask

    task automatic drain();
        int budget = 0;
        while (expq.size() > 0 && budget < 300) begin
            idle(1, 1'b1);
            budget++;
        end
        idle(2, 1'b1);
        chk("drain_remaining", expq.size(), 0);
    endtask

    function automatic logic [10:0] rand_bundle();
        int r = $urandom_range(0, 9);
        if (r < 6) return tbl_b[r];
        if (r == 6) return 11'h0;
        if (r == 7) return 11'b00000_011_000;
        return 11'($urandom);
    endfunction

    // Monitor: a handshake seen here completes on the following rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", {13'h0, out_count, out_word}, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_word", out_word, e.word);
                    chk("out_count", out_count, e.cnt);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        tbl_b[0] = 11'b00000_000_001; tbl_op[0] = 4'h0;
        tbl_b[1] = 11'b00011_000_011; tbl_op[1] = 4'h5;
        tbl_b[2] = 11'b10000_000_110; tbl_op[2] = 4'h6;
        tbl_b[3] = 11'b10100_010_000; tbl_op[3] = 4'h7;
        tbl_b[4] = 11'b00000_000_011; tbl_op[4] = 4'h8;
        tbl_b[5] = 11'b00000_100_011; tbl_op[5] = 4'h9;
        tbl_b[6] = 11'b00000_000_000; tbl_op[6] = 4'hF;
        ill_n = 0;

        rst_n = 1'b0; in_valid = 0; bnd = '0; flush = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_illegal_seen", illegal_seen, 0);
        chk("rst_illegal_count", illegal_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // ADD, LD, ST, CBZ -> 16'h7650 with one cycle of latency
        send(tbl_b[0], 0, 1); send(tbl_b[1], 0, 1);
        send(tbl_b[2], 0, 1); send(tbl_b[3], 0, 1);
        idle(1, 1'b1);
        #1 chk("t1_latency_valid", out_valid, 1);
        drain();

        // ADDI, ANDI, flush -> 16'hFF98; second flush must add nothing
        send(tbl_b[4], 0, 1); send(tbl_b[5], 0, 1);
        cycle(0, 11'h0, 1, 1, acc);
        idle(3, 1'b1);
        cycle(0, 11'h0, 1, 1, acc);
        idle(3, 1'b1);
        #1 chk("t2_no_second_word", out_valid, 0);
        drain();

        // 16 bundles with the consumer stalled fill the FIFO
        for (int i = 0; i < 16; i++) send(tbl_b[$urandom_range(0, 5)], 0, 0);
        idle(2, 1'b0);
        #1 chk("t3_full_in_ready", in_ready, 0);
        chk("t3_full_out_valid", out_valid, 1);
        idle(1, 1'b1);
        #1 chk("t3_ready_before_pop", in_ready, 0);
        idle(1, 1'b1);
        #1 chk("t3_ready_after_pop", in_ready, 1);
        drain();

        // Illegal bundle, then saturation of the counter
        send(11'b00000_011_000, 0, 1);
        idle(1, 1'b1);
        #1 chk("t4_illegal_seen", illegal_seen, 1);
        chk("t4_illegal_count", illegal_count, 1);
        cycle(0, 11'h0, 1, 1, acc);
        drain();
        for (int i = 0; i < 300; i++) send(11'b00000_011_000, 0, 1);
        drain();
        chk("t4_saturated", illegal_count, (ill_n > 255) ? 255 : ill_n);
        chk("t4_seen_sticky", illegal_seen, 1);

        // Flush on the 4th accept yields one full word; flush while full is harmless
        send(tbl_b[1], 0, 1); send(tbl_b[2], 0, 1); send(tbl_b[3], 0, 1);
        send(tbl_b[0], 1, 1);
        idle(3, 1'b1);
        drain();
        for (int i = 0; i < 16; i++) send(tbl_b[$urandom_range(0, 5)], 0, 0);
        cycle(0, 11'h0, 1, 0, acc);
        idle(2, 1'b0);
        #1 chk("t5_full_stall", in_ready, 0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        #1 chk("t5_ready_after_pop", in_ready, 1);
        send(tbl_b[5], 1, 0);
        drain();

        // Reset with two words queued and a partial word
        for (int i = 0; i < 10; i++) send(tbl_b[$urandom_range(0, 5)], 0, 0);
        idle(1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("t6_reset_out_valid", out_valid, 0);
        chk("t6_reset_illegal_count", illegal_count, 0);
        slots.delete(); expq.delete(); ill_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(tbl_b[3], 0, 1); send(tbl_b[2], 0, 1);
        send(tbl_b[1], 0, 1); send(tbl_b[0], 0, 1);
        drain();

        // Randomized traffic: bundles, flushes and consumer back-pressure
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_bundle(), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, acc);
        end
        cycle(0, 11'h0, 1, 1, acc);
        drain();
        chk("rand_illegal_count", illegal_count, (ill_n > 255) ? 255 : ill_n);
        chk("rand_illegal_seen", illegal_seen, (ill_n > 0) ? 1 : 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
